// File: rtl/dm_write_buffer.sv
// Posted-store write buffer between the core data port and memory: stores queue in a
// DEPTH-entry FIFO and drain in order, loads take the port at once. Optional macro: WB_FORWARD_EN.
module dm_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     WeDM,
  input  logic                     ReDM,
  input  logic [AW-1:0]            doutULA,
  input  logic [DW-1:0]            dinDM,
  output logic [DW-1:0]            doutDM,
  output logic                     stall,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_din,
  input  logic [DW-1:0]            mem_dout,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   wb_count
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_load;
  logic          w_match;
  logic          w_load_stall;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_idx;
`ifdef WB_FORWARD_EN
  logic [DW-1:0] w_fwd_data;
`endif

  assign wb_count = r_count;
  assign w_full   = (r_count == (PW+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_load   = ReDM && !WeDM;

  // Walk oldest to youngest so the last hit is the youngest matching entry.
  always_comb begin
    w_match = 1'b0;
    w_idx   = '0;
`ifdef WB_FORWARD_EN
    w_fwd_data = '0;
`endif
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PW'(k);
      if (((PW+1)'(k) < r_count) && (r_addr[w_idx][AW-1:3] == doutULA[AW-1:3])) begin
        w_match = 1'b1;
`ifdef WB_FORWARD_EN
        w_fwd_data = r_data[w_idx];
`endif
      end
    end
  end

`ifdef WB_FORWARD_EN
  assign w_load_stall = 1'b0;
  assign doutDM       = (w_load && w_match) ? w_fwd_data : mem_dout;
`else
  assign w_load_stall = w_load && w_match;
  assign doutDM       = mem_dout;
`endif

  // Strobes are gated by reset so a pending head never reaches memory during reset.
  assign stall = reset && ((WeDM && w_full) || w_load_stall);

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (w_load && !w_load_stall) begin
      mem_addr = doutULA;
    end else if (!w_empty) begin
      mem_we   = reset;
      mem_addr = r_addr[r_rd_ptr];
      mem_din  = r_data[r_rd_ptr];
    end
  end

  assign w_push = WeDM && !w_full;
  assign w_pop  = mem_we && mem_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= doutULA;
      r_data[r_wr_ptr] <= dinDM;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_dm_write_buffer.sv
// Self-checking bench for dm_write_buffer: directed scenarios plus random traffic
// checked against a queue-based reference model and a behavioural memory.
module tb_dm_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn, we, re, ready;
  logic [63:0] addr, din;
  logic [63:0] doutDM, mem_addr, mem_din, mem_dout;
  logic        stall, mem_we;
  logic [2:0]  wb_count;

  logic [63:0] mem_arr [256];
  logic [63:0] ref_mem [256];
  logic [63:0] qa [$];
  logic [63:0] qd [$];

  logic        e_stall, e_we, e_dchk;
  logic [63:0] e_addr, e_din, e_dout;

  int n_cmp = 0;
  int n_fail = 0;

  dm_write_buffer #(.DEPTH(DEPTH), .AW(64), .DW(64)) dut (
    .clk(clk), .reset(rstn), .WeDM(we), .ReDM(re), .doutULA(addr), .dinDM(din),
    .doutDM(doutDM), .stall(stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_ready(ready), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  assign mem_dout = mem_arr[mem_addr[10:3]];
  always @(posedge clk) if (mem_we && ready) mem_arr[mem_addr[10:3]] <= mem_din;

  // Reference model: expected outputs from the pending-store queue and current inputs.
  task automatic model_eval();
    logic        match, load, lstall;
    logic [63:0] fwd;
    match = 1'b0; fwd = '0;
    foreach (qa[i]) if (qa[i][63:3] == addr[63:3]) begin match = 1'b1; fwd = qd[i]; end
    load = re && !we;
`ifdef WB_FORWARD_EN
    lstall = 1'b0;
`else
    lstall = load && match;
`endif
    e_dchk = 1'b0; e_dout = '0; e_din = '0; e_addr = '0; e_we = 1'b0; e_stall = 1'b0;
    if (rstn) begin
      e_stall = (we && qa.size() == DEPTH) || lstall;
      if (load && !lstall) begin
        e_addr = addr;
        e_dchk = 1'b1;
        e_dout = match ? fwd : ref_mem[addr[10:3]];
      end else if (qa.size() > 0) begin
        e_we = 1'b1; e_addr = qa[0]; e_din = qd[0];
      end
    end
  endtask

  task automatic tick();
    logic full;
    model_eval();
    @(posedge clk);
    if (!rstn) begin
      qa.delete(); qd.delete();
    end else begin
      full = (qa.size() == DEPTH);
      if (e_we && ready) begin
        ref_mem[qa[0][10:3]] = qd[0];
        void'(qa.pop_front()); void'(qd.pop_front());
      end
      if (we && !full) begin qa.push_back(addr); qd.push_back(din); end
    end
    #1;
  endtask

  task automatic step(input logic r_n, input logic w, input logic rd,
                      input logic [63:0] a, input logic [63:0] d, input logic rdy);
    rstn = r_n; we = w; re = rd; addr = a; din = d; ready = rdy;
    #1;
  endtask

  task automatic drain_all();
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1, 0, 0, 0, 0, 1);
      tick();
    end
    n_cmp++;
    if (wb_count !== 3'd0) begin n_fail++; $display("FAIL drain_all wb_count got %0d want 0", wb_count); end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      step(0, 1, 0, 64'h40, 64'h1, 1);
      n_cmp++;
      if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset mem_we got %b want 0", mem_we); end
      n_cmp++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL reset stall got %b want 0", stall); end
      tick();
      n_cmp++;
      if (wb_count !== 3'd0) begin n_fail++; $display("FAIL reset wb_count got %0d want 0", wb_count); end
    end
  endtask

  task automatic test_fill_stall_drain();
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 0, 64'h100 + 64'(8*k), 64'h1000 + 64'(k), 0);
      tick();
    end
    n_cmp++;
    if (wb_count !== 3'd4) begin n_fail++; $display("FAIL fill wb_count got %0d want 4", wb_count); end
    step(1, 1, 0, 64'h120, 64'h1004, 0);
    n_cmp++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL full_stall got %b want 1", stall); end
    tick();
    n_cmp++;
    if (wb_count !== 3'd4) begin n_fail++; $display("FAIL full_hold wb_count got %0d want 4", wb_count); end
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 0, 0, 1);
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== 64'h100 + 64'(8*k) || mem_din !== 64'h1000 + 64'(k)) begin
        n_fail++;
        $display("FAIL drain_order[%0d] got we=%b a=%h d=%h want we=1 a=%h d=%h", k, mem_we, mem_addr,
                 mem_din, 64'h100 + 64'(8*k), 64'h1000 + 64'(k));
      end
      tick();
    end
    n_cmp++;
    if (wb_count !== 3'd0) begin n_fail++; $display("FAIL drained wb_count got %0d want 0", wb_count); end
    n_cmp++;
    if (mem_arr[8'h23] !== 64'h1003) begin n_fail++; $display("FAIL mem_0x118 got %h want 1003", mem_arr[8'h23]); end
  endtask

  task automatic test_push_pop_wrap();
    for (int j = 0; j < 2; j++) begin
      step(1, 1, 0, 64'h180 + 64'(8*j), 64'h3000 + 64'(j), 0);
      tick();
    end
    for (int j = 2; j < 12; j++) begin
      step(1, 1, 0, 64'h180 + 64'(8*j), 64'h3000 + 64'(j), 1);
      n_cmp++;
      if (mem_addr !== 64'h180 + 64'(8*(j-2)) || mem_din !== 64'h3000 + 64'(j-2)) begin
        n_fail++;
        $display("FAIL pushpop_head[%0d] got a=%h d=%h want a=%h d=%h", j, mem_addr, mem_din,
                 64'h180 + 64'(8*(j-2)), 64'h3000 + 64'(j-2));
      end
      tick();
      n_cmp++;
      if (wb_count !== 3'd2) begin n_fail++; $display("FAIL pushpop_count[%0d] got %0d want 2", j, wb_count); end
    end
    for (int j = 10; j < 12; j++) begin
      step(1, 0, 0, 0, 0, 1);
      n_cmp++;
      if (mem_addr !== 64'h180 + 64'(8*j)) begin
        n_fail++; $display("FAIL wrap_tail[%0d] got %h want %h", j, mem_addr, 64'h180 + 64'(8*j));
      end
      tick();
    end
  endtask

  task automatic test_forward();
    int n_st;
    step(1, 1, 0, 64'h200, 64'hDEAD, 0); tick();
    step(1, 1, 0, 64'h200, 64'hBEEF, 0); tick();
`ifdef WB_FORWARD_EN
    step(1, 0, 1, 64'h200, 0, 1);
    n_cmp++;
    if (doutDM !== 64'hBEEF || stall !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL fwd_load got d=%h st=%b we=%b want d=beef st=0 we=0", doutDM, stall, mem_we);
    end
    tick();
    drain_all();
`else
    n_st = 0;
    for (int c = 0; c < 8; c++) begin
      step(1, 0, 1, 64'h200, 0, 1);
      if (stall !== 1'b1) break;
      n_st++;
      tick();
    end
    n_cmp++;
    if (n_st != 2) begin n_fail++; $display("FAIL load_stall_cycles got %0d want 2", n_st); end
    n_cmp++;
    if (doutDM !== 64'hBEEF || stall !== 1'b0) begin
      n_fail++; $display("FAIL load_after_drain got d=%h st=%b want d=beef st=0", doutDM, stall);
    end
    tick();
`endif
  endtask

  task automatic test_load_nomatch();
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 64'h400 + 64'(8*k), 64'h4000 + 64'(k), 0);
      tick();
    end
    step(1, 0, 1, 64'h300, 0, 1);
    n_cmp++;
    if (doutDM !== 64'hA5A5A5A5_00000060 || mem_we !== 1'b0 || stall !== 1'b0 || mem_addr !== 64'h300) begin
      n_fail++;
      $display("FAIL load_nomatch got d=%h we=%b st=%b a=%h want d=a5a5a5a500000060 we=0 st=0 a=300",
               doutDM, mem_we, stall, mem_addr);
    end
    tick();
    n_cmp++;
    if (wb_count !== 3'd3) begin n_fail++; $display("FAIL drain_paused got %0d want 3", wb_count); end
    step(1, 0, 0, 0, 0, 1);
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 64'h400) begin
      n_fail++; $display("FAIL drain_resume got we=%b a=%h want we=1 a=400", mem_we, mem_addr);
    end
    tick();
    drain_all();
  endtask

  task automatic test_reset_middrain();
    logic bad;
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 64'h500 + 64'(8*k), 64'h5000 + 64'(k), 0);
      tick();
    end
    step(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_pulse mem_we got %b want 0", mem_we); end
    tick();
    n_cmp++;
    if (wb_count !== 3'd0) begin n_fail++; $display("FAIL rst_pulse wb_count got %0d want 0", wb_count); end
    for (int c = 0; c < 3; c++) begin
      step(1, 0, 0, 0, 0, 1);
      n_cmp++;
      if (mem_we !== 1'b0) begin n_fail++; $display("FAIL post_rst mem_we[%0d] got %b want 0", c, mem_we); end
      tick();
    end
    bad = 1'b0;
    for (int i = 0; i < 256; i++) if (mem_arr[i] !== ref_mem[i]) bad = 1'b1;
    n_cmp++;
    if (bad) begin n_fail++; $display("FAIL post_rst memory got changed want unchanged"); end
  endtask

  task automatic test_random();
    logic bad;
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 35),
           64'h600 + 64'(8 * $urandom_range(0, 7)) + 64'($urandom_range(0, 7)),
           {$urandom, $urandom}, ($urandom_range(0, 99) < 50));
      if (we && re && $urandom_range(0, 3) != 0) re = 1'b0;
      #1;
      model_eval();
      n_cmp++;
      if (stall !== e_stall || mem_we !== e_we) begin
        n_fail++; $display("FAIL rnd_ctl[%0d] got st=%b we=%b want st=%b we=%b", c, stall, mem_we, e_stall, e_we);
      end
      if (rstn) begin
        n_cmp++;
        if (mem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr[%0d] got %h want %h", c, mem_addr, e_addr); end
      end
      if (e_we) begin
        n_cmp++;
        if (mem_din !== e_din) begin n_fail++; $display("FAIL rnd_din[%0d] got %h want %h", c, mem_din, e_din); end
      end
      if (e_dchk) begin
        n_cmp++;
        if (doutDM !== e_dout) begin n_fail++; $display("FAIL rnd_dout[%0d] got %h want %h", c, doutDM, e_dout); end
      end
      n_cmp++;
      if (wb_count !== 3'(qa.size())) begin
        n_fail++; $display("FAIL rnd_count[%0d] got %0d want %0d", c, wb_count, qa.size());
      end
      tick();
    end
    drain_all();
    bad = 1'b0;
    for (int i = 0; i < 256; i++) if (mem_arr[i] !== ref_mem[i]) bad = 1'b1;
    n_cmp++;
    if (bad) begin n_fail++; $display("FAIL rnd_memory got differing contents want model contents"); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = {32'hA5A5A5A5, 24'h0, 8'(i)};
      ref_mem[i] = {32'hA5A5A5A5, 24'h0, 8'(i)};
    end
    rstn = 1'b0; we = 1'b0; re = 1'b0; ready = 1'b0; addr = '0; din = '0;
    test_reset();
    test_fill_stall_drain();
    test_push_pop_wrap();
    test_forward();
    test_load_nomatch();
    test_reset_middrain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
